// File: rtl/cpu_stage_sequencer_pkg.sv
// cpu_stage_sequencer_pkg: state, status and Y86 icode encodings shared by the stage sequencer
package cpu_stage_sequencer_pkg;
  typedef enum logic [2:0] {
    SEQ_IDLE, SEQ_FETCH, SEQ_DECODE, SEQ_EXECUTE, SEQ_MEMORY, SEQ_WRITEBACK, SEQ_PCUPD, SEQ_HALT
  } seq_state_e;
  typedef enum logic [1:0] {STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS} stat_e;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  function automatic logic is_mem_icode(input logic [3:0] icode);
    return icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction
endpackage

// File: rtl/cpu_stage_sequencer_mem_timeout_counter.sv
// mem_timeout_counter: counts unacknowledged request cycles and flags the cycle the limit is reached
module mem_timeout_counter #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  logic [W-1:0] cnt_q, cnt_d;
  // Expiry is only possible in a counting cycle, so an ack in that cycle always wins
  assign expired_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == LAST);
  always_comb cnt_d = (clr_i || expired_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer: multi-cycle Y86 stage controller with memory handshakes, status and retire count
module cpu_stage_sequencer
  import cpu_stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             dmem_error_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_is_data_o,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             execute_en_o,
  output logic             memory_en_o,
  output logic             writeback_en_o,
  output logic             pc_en_o,
  output logic [1:0]       stat_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] retired_o
);
  seq_state_e       state_q;
  stat_e            stat_q;
  logic [3:0]       icode_q;
  logic [CNT_W-1:0] retired_q;
  logic mem_req_q, mem_is_data_q, busy_q;
  logic fetch_en_q, decode_en_q, execute_en_q, memory_en_q, writeback_en_q, pc_en_q;
  logic expired;
  mem_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (!mem_req_q || mem_ack_i),
    .en_i     (mem_req_q && !mem_ack_i),
    .expired_o(expired)
  );
  assign mem_req_o      = mem_req_q;
  assign mem_is_data_o  = mem_is_data_q;
  assign fetch_en_o     = fetch_en_q;
  assign decode_en_o    = decode_en_q;
  assign execute_en_o   = execute_en_q;
  assign memory_en_o    = memory_en_q;
  assign writeback_en_o = writeback_en_q;
  assign pc_en_o        = pc_en_q;
  assign stat_o         = stat_q;
  assign busy_o         = busy_q;
  assign retired_o      = retired_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q        <= SEQ_IDLE;
      stat_q         <= STAT_AOK;
      icode_q        <= I_HALT;
      retired_q      <= '0;
      mem_req_q      <= 1'b0;
      mem_is_data_q  <= 1'b0;
      busy_q         <= 1'b0;
      fetch_en_q     <= 1'b0;
      decode_en_q    <= 1'b0;
      execute_en_q   <= 1'b0;
      memory_en_q    <= 1'b0;
      writeback_en_q <= 1'b0;
      pc_en_q        <= 1'b0;
    end else begin
      fetch_en_q     <= 1'b0;
      decode_en_q    <= 1'b0;
      execute_en_q   <= 1'b0;
      memory_en_q    <= 1'b0;
      writeback_en_q <= 1'b0;
      pc_en_q        <= 1'b0;
      case (state_q)
        SEQ_IDLE:
          if (start_i) begin
            state_q       <= SEQ_FETCH;
            mem_req_q     <= 1'b1;
            mem_is_data_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        SEQ_FETCH:
          if (mem_ack_i) begin
            mem_req_q  <= 1'b0;
            fetch_en_q <= 1'b1;
            state_q    <= (imem_error_i || !instr_valid_i) ? SEQ_HALT : SEQ_DECODE;
            stat_q     <= imem_error_i ? STAT_ADR : !instr_valid_i ? STAT_INS : STAT_AOK;
            busy_q     <= !imem_error_i && instr_valid_i;
          end else if (expired) begin
            mem_req_q <= 1'b0;
            state_q   <= SEQ_HALT;
            stat_q    <= STAT_ADR;
            busy_q    <= 1'b0;
          end
        SEQ_DECODE: begin
          decode_en_q <= 1'b1;
          icode_q     <= icode_i;
          state_q     <= SEQ_EXECUTE;
        end
        SEQ_EXECUTE: begin
          execute_en_q  <= 1'b1;
          state_q       <= is_mem_icode(icode_q) ? SEQ_MEMORY : SEQ_WRITEBACK;
          mem_req_q     <= is_mem_icode(icode_q);
          mem_is_data_q <= is_mem_icode(icode_q);
        end
        SEQ_MEMORY:
          if (mem_ack_i) begin
            mem_req_q     <= 1'b0;
            mem_is_data_q <= 1'b0;
            memory_en_q   <= 1'b1;
            state_q       <= dmem_error_i ? SEQ_HALT : SEQ_WRITEBACK;
            stat_q        <= dmem_error_i ? STAT_ADR : STAT_AOK;
            busy_q        <= !dmem_error_i;
          end else if (expired) begin
            mem_req_q     <= 1'b0;
            mem_is_data_q <= 1'b0;
            state_q       <= SEQ_HALT;
            stat_q        <= STAT_ADR;
            busy_q        <= 1'b0;
          end
        SEQ_WRITEBACK: begin
          writeback_en_q <= 1'b1;
          state_q        <= SEQ_PCUPD;
        end
        SEQ_PCUPD: begin
          retired_q <= retired_q + 1'b1;
          pc_en_q   <= icode_q != I_HALT;
          mem_req_q <= icode_q != I_HALT;
          busy_q    <= icode_q != I_HALT;
          state_q   <= (icode_q == I_HALT) ? SEQ_HALT : SEQ_FETCH;
          stat_q    <= (icode_q == I_HALT) ? STAT_HLT : STAT_AOK;
        end
        SEQ_HALT: ;
      endcase
    end
endmodule
